gate_scanner: RTL and testbench



---
 rtl/gate_scanner_pkg.sv | 13 +
 rtl/gate_scanner.sv | 131 +++++++++++++
 tb/tb_gate_scanner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
package gate_scanner_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/gate_scanner.sv
// Exhaustively drives a small combinational gate, captures its truth table and
// compares it against an expected table.
module gate_scanner
  import gate_scanner_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN-1:0]        drive,
  input  logic                   sample,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [(1<<N_IN)-1:0]   mismatch_mask,
  output logic                   mismatch
);

  localparam int unsigned N_VEC = 1 << N_IN;

  if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
    $error("gate_scanner: N_IN must be in 1..4");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("gate_scanner: SETTLE must be in 1..15");
  end

  state_t             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]    drive_q, drive_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N_VEC-1:0]   table_q, table_d;
  logic [N_VEC-1:0]   mask_q, mask_d;
  logic               mis_q, mis_d;
  logic [N_VEC-1:0]   captured;

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    drive_d  = drive_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    table_d  = table_q;
    mask_d   = mask_q;
    mis_d    = mis_q;
    captured = table_q;
    captured[idx_q] = sample;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          drive_d = '0;
          cnt_d   = CNT_W'(SETTLE - 1);
          table_d = '0;
          mask_d  = '0;
          mis_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        table_d = captured;
        if (idx_q == N_IN'(N_VEC - 1)) begin
          // Mask uses the just-captured bit, not the stale table register.
          mask_d  = captured ^ expected;
          mis_d   = |(captured ^ expected);
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          drive_d = idx_q + N_IN'(1);
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        drive_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drive_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      mask_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      mask_q  <= mask_d;
      mis_q   <= mis_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign drive         = drive_q;
  assign table_out     = table_q;
  assign mismatch_mask = mask_q;
  assign mismatch      = mis_q;

endmodule

// File: tb/tb_gate_scanner.sv
// Bench for gate_scanner: two instances (SETTLE=1 and SETTLE=3) against a
// cycle-schedule model plus directed literal checks.
module tb_gate_scanner;

  localparam int N  = 2;
  localparam int NV = 4;
  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [NV-1:0] expected, gt0, gt1;
  logic          busy0, done0, mis0, busy1, done1, mis1;
  logic [N-1:0]  drive0, drive1;
  logic [NV-1:0] tab0, mask0, tab1, mask1;
  logic          sample0, sample1;

  // Stub gates: truth table gtX looked up by the applied vector.
  assign sample0 = gt0[drive0];
  assign sample1 = gt1[drive1];

  gate_scanner #(.N_IN(N), .SETTLE(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
    .drive(drive0), .sample(sample0), .expected(expected), .table_out(tab0),
    .mismatch_mask(mask0), .mismatch(mis0)
  );

  gate_scanner #(.N_IN(N), .SETTLE(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
    .drive(drive1), .sample(sample1), .expected(expected), .table_out(tab1),
    .mismatch_mask(mask1), .mismatch(mis1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit en_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Model: k = cycles since the accepting edge (0 = idle). Cycle k drives
  // vector (k-1)/(s+1); busy for k in 1..P, done at k = P+1.
  int            k [2] = '{0, 0};
  logic [NV-1:0] m_tab  [2] = '{'0, '0};
  logic [NV-1:0] m_mask [2] = '{'0, '0};
  logic          m_mis  [2] = '{1'b0, 1'b0};

  function automatic int s_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, p, v;
      logic [NV-1:0] g;
      s = s_of(i);
      p = (s + 1) * NV;
      g = (i == 0) ? gt0 : gt1;
      if (!rst_n) begin
        k[i] = 0; m_tab[i] = '0; m_mask[i] = '0; m_mis[i] = 1'b0;
      end else if (k[i] == 0) begin
        if (start) begin
          k[i] = 1; m_tab[i] = '0; m_mask[i] = '0; m_mis[i] = 1'b0;
        end
      end else begin
        v = (k[i] - 1) / (s + 1);
        if (k[i] <= p && (k[i] % (s + 1)) == 0) m_tab[i][v] = g[v];
        if (k[i] == p) begin
          m_mask[i] = m_tab[i] ^ expected;
          m_mis[i]  = |m_mask[i];
        end
        k[i] = (k[i] == p + 1) ? 0 : k[i] + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (en_chk) begin
      for (int i = 0; i < 2; i++) begin
        int s, p;
        logic eb, ed;
        s  = s_of(i);
        p  = (s + 1) * NV;
        eb = (k[i] >= 1 && k[i] <= p);
        ed = (k[i] == p + 1);
        chk($sformatf("busy%0d", i), 32'((i == 0) ? busy0 : busy1), 32'(eb));
        chk($sformatf("done%0d", i), 32'((i == 0) ? done0 : done1), 32'(ed));
        chk($sformatf("table%0d", i), 32'((i == 0) ? tab0 : tab1), 32'(m_tab[i]));
        chk($sformatf("mask%0d", i), 32'((i == 0) ? mask0 : mask1), 32'(m_mask[i]));
        chk($sformatf("mis%0d", i), 32'((i == 0) ? mis0 : mis1), 32'(m_mis[i]));
        if (!ed)
          chk($sformatf("drive%0d", i), 32'((i == 0) ? drive0 : drive1),
              eb ? 32'((k[i] - 1) / (s + 1)) : 32'd0);
      end
    end
  end

  // Length of the most recent busy run per instance.
  int run0 = 0, run1 = 0, last0 = 0, last1 = 0;
  always @(negedge clk) begin
    if (busy0) run0++; else if (run0 != 0) begin last0 = run0; run0 = 0; end
    if (busy1) run1++; else if (run1 != 0) begin last1 = run1; run1 = 0; end
  end

  task automatic wait_done(input int inst, input int max_cyc);
    int n;
    n = 0;
    while ((((inst == 0) ? done0 : done1) !== 1'b1) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done%0d_seen", inst), 32'(n < max_cyc), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  initial begin
    int nd, n;
    rst_n = 1'b0; start = 1'b1;
    gt0 = 4'b1000; gt1 = 4'b1000; expected = 4'b1000;

    // Reset held two edges with start high.
    @(posedge clk); @(negedge clk);
    en_chk = 1'b1;
    @(negedge clk);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_drive0", 32'(drive0), 32'd0);
    chk("rst_table0", 32'(tab0), 32'd0);
    chk("rst_mis1", 32'(mis1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("accept_busy0", 32'(busy0), 32'd1);
    chk("accept_busy1", 32'(busy1), 32'd1);
    start = 1'b0;

    // AND gate scan.
    wait_done(0, 20);
    wait_done(1, 30);
    idle(2);
    chk("and_table0", 32'(tab0), 32'h8);
    chk("and_mis0", 32'(mis0), 32'd0);
    chk("and_busy_len0", 32'(last0), 32'd8);
    chk("and_table1", 32'(tab1), 32'h8);
    chk("and_busy_len1", 32'(last1), 32'd16);

    // OR-like stub with stray starts in SETTLE and DONE.
    gt0 = 4'b1110; gt1 = 4'b1110;
    start = 1'b1; @(negedge clk); start = 1'b0;
    idle(2);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(0, 20);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_in_done_ignored", 32'(busy0), 32'd0);
    wait_done(1, 30);
    idle(2);
    chk("or_table0", 32'(tab0), 32'he);
    chk("or_mask0", 32'(mask0), 32'h6);
    chk("or_mis0", 32'(mis0), 32'd1);
    chk("or_mask1", 32'(mask1), 32'h6);

    // start held high: back-to-back scans with one idle cycle between.
    start = 1'b1;
    @(negedge clk);
    wait_done(0, 20);
    @(negedge clk);
    chk("b2b_gap_idle", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("b2b_restart", 32'(busy0), 32'd1);
    start = 1'b0;
    idle(40);

    // Reset during the idx=2 SETTLE cycle.
    gt0 = 4'b1111; gt1 = 4'b1111;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!(busy0 === 1'b1 && drive0 === 2'd2) && n < 20) begin @(negedge clk); n++; end
    chk("reach_idx2", 32'(n < 20), 32'd1);
    chk("pre_rst_table0", 32'(tab0), 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_table0", 32'(tab0), 32'd0);
    chk("mid_rst_drive0", 32'(drive0), 32'd0);
    chk("mid_rst_busy0", 32'(busy0), 32'd0);
    nd = 0;
    for (int j = 0; j < 30; j++) begin @(negedge clk); if (done0 || done1) nd++; end
    chk("mid_rst_no_done", 32'(nd), 32'd0);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      expected = 4'($urandom);
      if (k[0] == 0) gt0 = 4'($urandom);
      if (k[1] == 0) gt1 = 4'($urandom);
    end
    rst_n = 1'b1; start = 1'b0;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
